// File: rtl/aes_pkg.sv
// AES round primitives shared by the encryption core and its sub-blocks.
// Provides the S-box table, GF(2^8) xtime, MixColumns, ShiftRows, FSM type.
package aes_pkg;

   localparam int NR = 14;
   localparam int NK = 8;

   typedef enum logic {
      IDLE,
      RUN
   } fsm_t;

   // Row x of the table holds S(x*16 + 0) .. S(x*16 + 15).
   localparam logic [0:15][7:0] SROW [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SROW[b[7:4]][b[3:0]];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One state column, row 0 in the top byte.
   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]),
              mix_col(s[63:32]), mix_col(s[31:0])};
   endfunction

   // Byte i of the block is row i%4, column i/4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [0:15][7:0] b;
      b = s;
      return {b[0],  b[5],  b[10], b[15],
              b[4],  b[9],  b[14], b[3],
              b[8],  b[13], b[2],  b[7],
              b[12], b[1],  b[6],  b[11]};
   endfunction

endpackage

// File: rtl/aes_sub_bytes.sv
// 16 parallel S-box lanes, purely combinational.
// Ports: din (128-bit block in), dout (bytewise SubBytes of din).
module aes_sub_bytes
   import aes_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);

   for (genvar g = 0; g < 16; g++) begin : g_lane
      assign dout[127-8*g -: 8] = sbox(din[127-8*g -: 8]);
   end

endmodule

// File: rtl/aes256_enc_core.sv
// Iterative AES-256 encryptor, one round per clock, shares its S-box with keyex.
// Ports: round keys/key_ok in, plaintext handshake, ciphertext pulse, keyex S-box port.
module aes256_enc_core
   import aes_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1919:0]     i_exkey,
   input  logic              i_key_ok,
   input  logic [127:0]      i_din,
   input  logic              i_din_en,
   output logic              o_ready,
   output logic [127:0]      o_dout,
   output logic              o_dout_en,
   output logic              o_busy,
   input  logic              i_ks_sbox_use,
   input  logic [63:0]       i_ks_sbox_din,
   output logic [63:0]       o_ks_sbox_dout
);

   logic [0:NR][127:0] rk;
   fsm_t               fsm, fsm_nx;
   logic [127:0]       blk, blk_nx;
   logic [127:0]       ct, ct_nx;
   logic [3:0]         rnd, rnd_nx;
   logic               done, done_nx;
   logic [127:0]       sb_in, sb_out, sr, rnd_val;
   logic               last;

   assign rk = i_exkey;

   assign o_busy    = (fsm == RUN);
   assign o_ready   = i_key_ok & ~o_busy & ~i_ks_sbox_use;
   assign o_dout    = ct;
   assign o_dout_en = done;

   // Keyex borrows the upper eight lanes; the round stalls meanwhile.
   assign sb_in = i_ks_sbox_use ? {i_ks_sbox_din, blk[63:0]} : blk;

   aes_sub_bytes u_sub (
      .din  (sb_in),
      .dout (sb_out)
   );

   assign o_ks_sbox_dout = sb_out[127:64];

   assign sr      = shift_rows(sb_out);
   assign last    = (rnd == 4'(NR));
   assign rnd_val = (last ? sr : mix_cols(sr)) ^ rk[rnd];

   always_comb begin
      fsm_nx  = fsm;
      blk_nx  = blk;
      rnd_nx  = rnd;
      ct_nx   = ct;
      done_nx = 1'b0;
      case (fsm)
         IDLE: begin
            if (i_din_en && o_ready) begin
               blk_nx = i_din ^ rk[0];
               rnd_nx = 4'd1;
               fsm_nx = RUN;
            end
         end
         RUN: begin
            if (!i_key_ok) begin
               fsm_nx = IDLE;
            end else if (!i_ks_sbox_use) begin
               blk_nx = rnd_val;
               if (last) begin
                  ct_nx   = rnd_val;
                  done_nx = 1'b1;
                  fsm_nx  = IDLE;
               end else begin
                  rnd_nx = rnd + 4'd1;
               end
            end
         end
         default: fsm_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fsm  <= IDLE;
         blk  <= '0;
         rnd  <= '0;
         ct   <= '0;
         done <= 1'b0;
      end else begin
         fsm  <= fsm_nx;
         blk  <= blk_nx;
         rnd  <= rnd_nx;
         ct   <= ct_nx;
         done <= done_nx;
      end
   end

endmodule

// File: tb/tb_aes256_enc_core.sv
// Self-checking bench for aes256_enc_core against a byte-level AES-256 model.
// The bench plays the key expander: it drives round keys, key_ok and S-box requests.
module tb_aes256_enc_core;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1919:0] exkey;
   logic          key_ok;
   logic [127:0]  din;
   logic          din_en;
   logic          ready;
   logic [127:0]  dout;
   logic          dout_en;
   logic          busy;
   logic          ks_use;
   logic [63:0]   ks_din;
   logic [63:0]   ks_dout;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sb [256];

   always #5 clk = ~clk;

   aes256_enc_core dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_exkey        (exkey),
      .i_key_ok       (key_ok),
      .i_din          (din),
      .i_din_en       (din_en),
      .o_ready        (ready),
      .o_dout         (dout),
      .o_dout_en      (dout_en),
      .o_busy         (busy),
      .i_ks_sbox_use  (ks_use),
      .i_ks_sbox_din  (ks_din),
      .o_ks_sbox_dout (ks_dout)
   );

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: GF inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] x, y, inv;
      for (int i = 0; i < 256; i++) begin
         x = 8'(i);
         inv = 8'h00;
         for (int j = 1; j < 256; j++) begin
            y = 8'(j);
            if (gmul(x, y) == 8'h01) inv = y;
         end
         sb[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic logic [63:0] sub64(logic [63:0] v);
      return {subw(v[63:32]), subw(v[31:0])};
   endfunction

   function automatic logic [1919:0] expand(logic [255:0] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] e;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int i = 0; i < 60; i++) e[1919-32*i -: 32] = w[i];
      return e;
   endfunction

   function automatic logic [127:0] encrypt(logic [1919:0] e, logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] out;
      for (int i = 0; i < 16; i++)
         s[i] = pt[127-8*i -: 8] ^ e[1919-8*i -: 8];
      for (int r = 1; r <= 14; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               t[w+4*c] = s[w+4*((c+w)%4)];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            if (r < 14) begin
               s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
               s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
            end else begin
               s[4*c]   = a0;
               s[4*c+1] = a1;
               s[4*c+2] = a2;
               s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++)
            s[i] = s[i] ^ e[1919-128*r-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
      return out;
   endfunction

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one block for a single cycle; acc reports o_ready at the edge.
   task automatic send(input logic [127:0] pt, output logic acc);
      din    = pt;
      din_en = 1'b1;
      #1;
      acc = ready;
      step();
      din_en = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (dout_en !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      key_ok = 1'b0;
      step();
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b want=0", busy);
      end
      checks++;
      if (dout !== 128'h0) begin
         failures++;
         $display("FAIL reset_dout got=%h want=0", dout);
      end
      checks++;
      if (dout_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_dout_en got=%b want=0", dout_en);
      end
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready_nokey got=%b want=0", ready);
      end
      key_ok = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready_key got=%b want=1", ready);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fips();
      logic [255:0] key;
      logic [127:0] pt, ct;
      logic         acc;
      int           n;
      key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      pt  = 128'h00112233445566778899aabbccddeeff;
      ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
      exkey  = expand(key);
      key_ok = 1'b1;
      checks++;
      if (encrypt(exkey, pt) !== ct) begin
         failures++;
         $display("FAIL fips_model got=%h want=%h", encrypt(exkey, pt), ct);
      end
      send(pt, acc);
      checks++;
      if (acc !== 1'b1) begin
         failures++;
         $display("FAIL fips_accept got=%b want=1", acc);
      end
      wait_done(n);
      checks++;
      if (n != 14) begin
         failures++;
         $display("FAIL fips_latency got=%0d want=14", n);
      end
      checks++;
      if (dout !== ct) begin
         failures++;
         $display("FAIL fips_ct got=%h want=%h", dout, ct);
      end
      step();
      checks++;
      if (dout_en !== 1'b0 || dout !== ct) begin
         failures++;
         $display("FAIL fips_hold en=%b dout=%h want en=0 dout=%h",
                  dout_en, dout, ct);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] pt0, pt1;
      logic         acc;
      int           n;
      pt0 = 128'h0;
      pt1 = rand128();
      send(pt0, acc);
      wait_done(n);
      checks++;
      if (n != 14 || dout !== encrypt(exkey, pt0)) begin
         failures++;
         $display("FAIL b2b_first lat=%0d ct=%h want lat=14 ct=%h",
                  n, dout, encrypt(exkey, pt0));
      end
      send(pt1, acc);
      checks++;
      if (acc !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept got=%b want=1", acc);
      end
      wait_done(n);
      checks++;
      if (n != 14 || dout !== encrypt(exkey, pt1)) begin
         failures++;
         $display("FAIL b2b_second lat=%0d ct=%h want lat=14 ct=%h",
                  n, dout, encrypt(exkey, pt1));
      end
      step();
   endtask

   task automatic test_not_ready();
      logic [127:0] pa;
      logic         acc;
      int           n, pulses;
      key_ok = 1'b0;
      din    = rand128();
      din_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL nokey_busy cyc=%0d got=%b want=0", i, busy);
         end
      end
      din_en = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dout_en === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL nokey_pulses got=%0d want=0", pulses);
      end
      key_ok = 1'b1;
      pa = rand128();
      send(pa, acc);
      din    = rand128();
      din_en = 1'b1;
      for (int i = 0; i < 3; i++) step();
      din_en = 1'b0;
      wait_done(n);
      checks++;
      if (n + 3 != 14 || dout !== encrypt(exkey, pa)) begin
         failures++;
         $display("FAIL busy_ignore lat=%0d ct=%h want lat=14 ct=%h",
                  n + 3, dout, encrypt(exkey, pa));
      end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dout_en === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL busy_noqueue pulses=%0d want=0", pulses);
      end
   endtask

   task automatic test_stall();
      logic [127:0] pt;
      logic         acc;
      int           n;
      exkey = expand(rand256());
      pt    = rand128();
      ks_use = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL sbox_idle_ready got=%b want=0", ready);
      end
      ks_use = 1'b0;
      send(pt, acc);
      for (int i = 0; i < 4; i++) step();
      ks_use = 1'b1;
      ks_din = 64'h0001_5300_0000_0000;
      #1;
      checks++;
      if (ks_dout !== 64'h637c_ed63_6363_6363) begin
         failures++;
         $display("FAIL sbox_example got=%h want=637ced6363636363", ks_dout);
      end
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
         failures++;
         $display("FAIL stall_flags busy=%b ready=%b want 1 0", busy, ready);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         ks_din = {$urandom, $urandom};
         #1;
         checks++;
         if (ks_dout !== sub64(ks_din)) begin
            failures++;
            $display("FAIL sbox_rand in=%h got=%h want=%h",
                     ks_din, ks_dout, sub64(ks_din));
         end
      end
      step();
      ks_use = 1'b0;
      wait_done(n);
      checks++;
      if (n + 7 != 17) begin
         failures++;
         $display("FAIL stall_latency got=%0d want=17", n + 7);
      end
      checks++;
      if (dout !== encrypt(exkey, pt)) begin
         failures++;
         $display("FAIL stall_ct got=%h want=%h", dout, encrypt(exkey, pt));
      end
      step();
   endtask

   task automatic test_abort();
      logic [127:0] old, pt;
      logic [255:0] k2;
      logic         acc;
      int           n, pulses;
      old = dout;
      k2  = rand256();
      send(rand128(), acc);
      for (int i = 0; i < 5; i++) step();
      key_ok = 1'b0;
      exkey  = {$urandom, 1888'h0};
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_busy got=%b want=0", busy);
      end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dout_en === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || dout !== old) begin
         failures++;
         $display("FAIL abort_out pulses=%0d dout=%h want 0 %h",
                  pulses, dout, old);
      end
      exkey  = expand(k2);
      key_ok = 1'b1;
      pt     = rand128();
      send(pt, acc);
      wait_done(n);
      checks++;
      if (n != 14 || dout !== encrypt(exkey, pt)) begin
         failures++;
         $display("FAIL abort_rekey lat=%0d ct=%h want lat=14 ct=%h",
                  n, dout, encrypt(exkey, pt));
      end
      step();
   endtask

   task automatic test_random();
      logic [127:0] pt;
      logic         acc;
      int           n;
      for (int k = 0; k < 4; k++) begin
         exkey = expand(rand256());
         pt    = rand128();
         send(pt, acc);
         wait_done(n);
         checks++;
         if (acc !== 1'b1 || n != 14 || dout !== encrypt(exkey, pt)) begin
            failures++;
            $display("FAIL rand%0d acc=%b lat=%0d ct=%h want 1 14 %h",
                     k, acc, n, dout, encrypt(exkey, pt));
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic acc;
      send(rand128(), acc);
      for (int i = 0; i < 6; i++) step();
      rst_n = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || dout !== 128'h0 || dout_en !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid busy=%b dout=%h en=%b want 0 0 0",
                  busy, dout, dout_en);
      end
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_ready_key got=%b want=1", ready);
      end
      key_ok = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_ready_nokey got=%b want=0", ready);
      end
      rst_n  = 1'b1;
      key_ok = 1'b1;
      step();
   endtask

   initial begin
      rst_n  = 1'b0;
      exkey  = '0;
      key_ok = 1'b0;
      din    = '0;
      din_en = 1'b0;
      ks_use = 1'b0;
      ks_din = '0;
      build_sbox();
      test_reset();
      test_fips();
      test_back_to_back();
      test_not_ready();
      test_stall();
      test_abort();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
